jtframe_dump_ctrl: RTL and testbench

Synthesizable scheduler for the simulation waveform-dump resource.
- Counts video frames on VSYNC falling edges.
- Arms after ROM download completes.
- Opens one dump window at a programmed start frame and closes it after a programmed length.
- Issues a one-shot finish request.
- The bench wrapper turns dump_start, dump_stop and sim_finish into dump on, dump off and finish calls. This keeps trigger logic in RTL, where it can be checked, rather than in ad-hoc initial blocks.

---
 rtl/jtframe_dump_pkg.sv | 20 ++
 rtl/jtframe_dump_edge.sv | 21 ++
 rtl/jtframe_dump_ctrl.sv | 139 +++++++++++++
 tb/tb_jtframe_dump_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dump_pkg.sv
// Shared types for the waveform-dump scheduler: state encoding, default
// counter width and the registered pulse record.
package jtframe_dump_pkg;

    localparam int DEF_CNTW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DUMPING = 2'd2,
        ST_DONE    = 2'd3
    } dump_st_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic finish;
    } dump_pulse_t;

endpackage

// File: rtl/jtframe_dump_edge.sv
// Rise/fall detector against a registered copy of the input; single clock
// domain, so no synchronizer stage.
module jtframe_dump_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_l <= 1'b0;
        else     din_l <= din;
    end

    assign rise = din & ~din_l;
    assign fall = din_l & ~din;

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Waveform-dump scheduler: counts frames, opens/closes one dump window and
// requests finish. Define JTFRAME_DUMP_DWN_TRIG_EN to open the window on download end.
module jtframe_dump_ctrl
    import jtframe_dump_pkg::*;
#(
    parameter logic [15:0] DWN_GUARD = 16'd2000,
    parameter int          CNTW      = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    input  logic            downloading,
    input  logic [CNTW-1:0] start_frame,
    input  logic [15:0]     dump_len,
    input  logic [CNTW-1:0] finish_frame,
    output logic [CNTW-1:0] frame_cnt,
    output logic            dump_on,
    output logic            dump_start,
    output logic            dump_stop,
    output logic            sim_finish,
    output logic [1:0]      st
);

    dump_st_t    state;
    dump_pulse_t pls;
    logic [15:0] guard, len_cnt;
    logic        frame_edge, unused_vs_rise, dwn_rise, dwn_fall_raw;
    logic        dwn_ok, dwn_fall, never_dwn, fin_done, fin_hit, start_hit;

    jtframe_dump_edge u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (vs),
        .rise (unused_vs_rise),
        .fall (frame_edge)
    );

    jtframe_dump_edge u_dwn_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (downloading),
        .rise (dwn_rise),
        .fall (dwn_fall_raw)
    );

    // A download that ends inside the guard window is the power-up glitch
    assign dwn_ok    = (guard == DWN_GUARD);
    assign dwn_fall  = dwn_fall_raw & dwn_ok;
    assign fin_hit   = frame_edge && (finish_frame != '0) &&
                       (frame_cnt == finish_frame) && !fin_done;
    assign start_hit = frame_edge && (frame_cnt == start_frame);

    assign st         = state;
    assign dump_start = pls.start;
    assign dump_stop  = pls.stop;
    assign sim_finish = pls.finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    guard <= 16'd0;
        else if (guard != DWN_GUARD) guard <= guard + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   frame_cnt <= '0;
        else if (downloading)                      frame_cnt <= '0;
        else if (frame_edge && frame_cnt != '1)    frame_cnt <= frame_cnt + CNTW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pls       <= '0;
            dump_on   <= 1'b0;
            len_cnt   <= 16'd0;
            fin_done  <= 1'b0;
            never_dwn <= 1'b1;
        end else begin
            pls <= '0;
            if (downloading) never_dwn <= 1'b0;

            // A fresh download aborts everything, including an open window
            if (dwn_rise && state != ST_IDLE) begin
                state    <= ST_IDLE;
                fin_done <= 1'b0;
                if (state == ST_DUMPING) begin
                    pls.stop <= 1'b1;
                    dump_on  <= 1'b0;
                end
            end else if (fin_hit) begin
                pls.finish <= 1'b1;
                fin_done   <= 1'b1;
                if (state == ST_DUMPING) begin
                    pls.stop <= 1'b1;
                    dump_on  <= 1'b0;
                    state    <= ST_DONE;
                end else if (state == ST_ARMED && start_hit) begin
                    state <= ST_DONE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (dwn_fall) begin
`ifdef JTFRAME_DUMP_DWN_TRIG_EN
                            state     <= ST_DUMPING;
                            pls.start <= 1'b1;
                            dump_on   <= 1'b1;
                            len_cnt   <= 16'd0;
`else
                            state <= ST_ARMED;
`endif
                        end else if (never_dwn && dwn_ok && !downloading) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (start_hit) begin
                            state     <= ST_DUMPING;
                            pls.start <= 1'b1;
                            dump_on   <= 1'b1;
                            len_cnt   <= 16'd0;
                        end
                    end
                    ST_DUMPING: begin
                        if (frame_edge) begin
                            if (len_cnt != 16'hffff) len_cnt <= len_cnt + 16'd1;
                            if (dump_len != 16'd0 && (len_cnt + 16'd1) == dump_len) begin
                                state    <= ST_DONE;
                                pls.stop <= 1'b1;
                                dump_on  <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_DONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Scoreboard bench for jtframe_dump_ctrl: stimulus queues expected pulses and
// state probes, a negedge monitor pops and compares them.
module tb_jtframe_dump_ctrl;

    localparam int CNTW  = 32;
    localparam int LIMIT = 60000;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_DUMP = 2'd2, S_DONE = 2'd3;
    localparam logic [2:0] P_NONE = 3'b000, P_START = 3'b100, P_STOP = 3'b010, P_FIN = 3'b001;

    logic            clk = 1'b0, rst = 1'b1, vs = 1'b0, downloading = 1'b0;
    logic [CNTW-1:0] start_frame = '0, finish_frame = '0;
    logic [15:0]     dump_len = '0;
    logic [CNTW-1:0] frame_cnt;
    logic            dump_on, dump_start, dump_stop, sim_finish;
    logic [1:0]      st;

    typedef struct {
        logic [2:0]      m;
        logic [CNTW-1:0] cnt;
        logic [1:0]      s;
        logic            on;
        int              cyc;
    } exp_t;

    exp_t pulse_q[$];
    exp_t probe_q[$];
    int   cyc = 0, n_chk = 0, n_fail = 0;
    logic done = 1'b0;

    jtframe_dump_ctrl #(.DWN_GUARD(16'd2000), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .vs           (vs),
        .downloading  (downloading),
        .start_frame  (start_frame),
        .dump_len     (dump_len),
        .finish_frame (finish_frame),
        .frame_cnt    (frame_cnt),
        .dump_on      (dump_on),
        .dump_start   (dump_start),
        .dump_stop    (dump_stop),
        .sim_finish   (sim_finish),
        .st           (st)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_pulse(input logic [2:0] m, input logic [CNTW-1:0] c,
                              input logic [1:0] s, input logic on, input int at);
        exp_t e;
        e.m = m; e.cnt = c; e.s = s; e.on = on; e.cyc = at;
        pulse_q.push_back(e);
    endtask

    task automatic probe_at(input int at, input logic [1:0] s,
                            input logic [CNTW-1:0] c, input logic on);
        exp_t e;
        e.m = P_NONE; e.cnt = c; e.s = s; e.on = on; e.cyc = at;
        probe_q.push_back(e);
    endtask

    task automatic probe(input logic [1:0] s, input logic [CNTW-1:0] c, input logic on);
        probe_at(cyc + 1, s, c, on);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame; the falling vs edge is seen at the next posedge
    task automatic frame(input logic [2:0] m, input logic [CNTW-1:0] c,
                         input logic [1:0] s, input logic on);
        @(negedge clk) vs = 1'b1;
        wait_cyc(2);
        vs = 1'b0;
        if (m != P_NONE) push_pulse(m, c, s, on, cyc + 1);
        wait_cyc(6);
    endtask

    task automatic do_reset(input logic dl);
        @(negedge clk);
        rst = 1'b1; vs = 1'b0; downloading = dl;
        probe(S_IDLE, 0, 1'b0);
        wait_cyc(3);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            e = pulse_q.pop_front();
            n_chk++; n_fail++;
            $display("FAIL missing_pulse: required start/stop/fin=%b at cycle %0d, nothing seen", e.m, e.cyc);
        end
        if (dump_start || dump_stop || sim_finish) begin
            n_chk++;
            if (pulse_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got start/stop/fin=%b at cycle %0d, required none",
                         {dump_start, dump_stop, sim_finish}, cyc);
            end else begin
                e = pulse_q.pop_front();
                if ({dump_start, dump_stop, sim_finish} !== e.m || frame_cnt !== e.cnt ||
                    st !== e.s || dump_on !== e.on || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got pls=%b cnt=%0d st=%0d on=%b cyc=%0d, required pls=%b cnt=%0d st=%0d on=%b cyc=%0d",
                             {dump_start, dump_stop, sim_finish}, frame_cnt, st, dump_on, cyc,
                             e.m, e.cnt, e.s, e.on, e.cyc);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            e = probe_q.pop_front();
            n_chk++;
            if (e.cyc != cyc || st !== e.s || frame_cnt !== e.cnt || dump_on !== e.on) begin
                n_fail++;
                $display("FAIL probe: got st=%0d cnt=%0d on=%b at cycle %0d, required st=%0d cnt=%0d on=%b at cycle %0d",
                         st, frame_cnt, dump_on, cyc, e.s, e.cnt, e.on, e.cyc);
            end
        end
        if (done || cyc > LIMIT) begin
            if (!done) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: got cycle %0d, required finish before %0d", cyc, LIMIT);
            end
            while (pulse_q.size() > 0) begin
                e = pulse_q.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missing_pulse: required start/stop/fin=%b at cycle %0d, nothing seen", e.m, e.cyc);
            end
            while (probe_q.size() > 0) begin
                e = probe_q.pop_front();
                n_chk++; n_fail++;
                $display("FAIL probe_unchecked: required st=%0d at cycle %0d, never sampled", e.s, e.cyc);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
`ifndef JTFRAME_DUMP_DWN_TRIG_EN
        // Download ends after 3000 cycles, window frames 5..8
        start_frame = 5; dump_len = 3; finish_frame = 0;
        do_reset(1'b1);
        wait_cyc(3000);
        downloading = 1'b0;
        probe(S_ARMED, 0, 1'b0);
        wait_cyc(3);
        for (int i = 0; i < 10; i++) begin
            if (i == 5)      frame(P_START, 6, S_DUMP, 1'b1);
            else if (i == 8) frame(P_STOP, 9, S_DONE, 1'b0);
            else             frame(P_NONE, 0, S_IDLE, 1'b0);
        end
        probe(S_DONE, 10, 1'b0);
        wait_cyc(2);

        // Early download inside the guard is ignored; later one arms
        do_reset(1'b1);
        wait_cyc(97);
        downloading = 1'b0;
        wait_cyc(2500);
        probe(S_IDLE, 0, 1'b0);
        wait_cyc(2);
        downloading = 1'b1;
        wait_cyc(2400);
        downloading = 1'b0;
        probe(S_ARMED, 0, 1'b0);
        wait_cyc(3);

        // Finish while dumping with unlimited length
        start_frame = 2; dump_len = 0; finish_frame = 8;
        for (int i = 0; i < 12; i++) begin
            if (i == 2)      frame(P_START, 3, S_DUMP, 1'b1);
            else if (i == 8) frame(P_STOP | P_FIN, 9, S_DONE, 1'b0);
            else             frame(P_NONE, 0, S_IDLE, 1'b0);
        end
        probe(S_DONE, 12, 1'b0);
        wait_cyc(2);
`endif
        // No-download run; start and finish on the same edge
        start_frame = 4; finish_frame = 4; dump_len = 2;
        do_reset(1'b0);
        wait_cyc(2010);
        probe(S_ARMED, 0, 1'b0);
        wait_cyc(2);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) frame(P_FIN, 5, S_DONE, 1'b0);
            else        frame(P_NONE, 0, S_IDLE, 1'b0);
        end
        probe(S_DONE, 7, 1'b0);
        wait_cyc(2);
`ifndef JTFRAME_DUMP_DWN_TRIG_EN
        // Re-download out of DONE, then a download aborting an open window
        start_frame = 3; finish_frame = 0; dump_len = 0;
        downloading = 1'b1;
        wait_cyc(5);
        probe(S_IDLE, 0, 1'b0);
        wait_cyc(2);
        downloading = 1'b0;
        probe(S_ARMED, 0, 1'b0);
        wait_cyc(3);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) frame(P_START, 4, S_DUMP, 1'b1);
            else        frame(P_NONE, 0, S_IDLE, 1'b0);
        end
        downloading = 1'b1;
        push_pulse(P_STOP, 0, S_IDLE, 1'b0, cyc + 1);
        wait_cyc(3);
        probe(S_IDLE, 0, 1'b0);
        wait_cyc(2);
        downloading = 1'b0;
        probe(S_ARMED, 0, 1'b0);
        wait_cyc(3);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) frame(P_START, 4, S_DUMP, 1'b1);
            else        frame(P_NONE, 0, S_IDLE, 1'b0);
        end
        // Asynchronous reset mid-window: dump_on must drop before the next edge
        @(posedge clk);
        #2 rst = 1'b1;
        probe_at(cyc, S_IDLE, 0, 1'b0);
        wait_cyc(3);
        rst = 1'b0;
`else
        // Download end opens the window directly, start_frame ignored
        start_frame = 50; dump_len = 2; finish_frame = 0;
        do_reset(1'b1);
        wait_cyc(2100);
        downloading = 1'b0;
        push_pulse(P_START, 0, S_DUMP, 1'b1, cyc + 1);
        wait_cyc(3);
        frame(P_NONE, 0, S_IDLE, 1'b0);
        frame(P_STOP, 2, S_DONE, 1'b0);
        probe(S_DONE, 2, 1'b0);
        wait_cyc(2);
`endif
        wait_cyc(5);
        done = 1'b1;
    end

endmodule
